// File: rtl/vga_pkg.sv
// Shared types and constants for the configurable VGA pattern generator.
package vga_pkg;

  typedef enum logic [1:0] {
    GRID   = 2'd0,
    BARS   = 2'd1,
    SOLID  = 2'd2,
    STREAM = 2'd3
  } mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Element 0 is the leftmost bar.
  localparam logic [0:7][23:0] BAR_PAL = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic int unsigned vga_total(input int unsigned fp, input int unsigned pulse,
                                            input int unsigned bp, input int unsigned disp);
    return fp + pulse + bp + disp;
  endfunction

endpackage

// File: rtl/video_if.sv
// Video bus toward the HDMI/LCD output stage.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;

  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input  CLK, HS, VS, BLANK, RGB);
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical counters and region decode; line order is FP, sync, BP, active.
module vga_timing
  import vga_pkg::*;
#(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29,
  localparam int HTOT  = int'(vga_total(HFP, HPULSE, HBP, HDISP)),
  localparam int VTOT  = int'(vga_total(VFP, VPULSE, VBP, VDISP)),
  localparam int HW    = $clog2(HTOT),
  localparam int VW    = $clog2(VTOT)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          h_sync,
  output logic          v_sync,
  output logic          active,
  output logic          frame_first,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y
);

  localparam logic [HW-1:0] H_LAST = HW'(HTOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VTOT - 1);
  localparam logic [HW-1:0] H_SS   = HW'(HFP);
  localparam logic [HW-1:0] H_SE   = HW'(HFP + HPULSE - 1);
  localparam logic [VW-1:0] V_SS   = VW'(VFP);
  localparam logic [VW-1:0] V_SE   = VW'(VFP + VPULSE - 1);
  localparam logic [HW-1:0] H_AS   = HW'(HTOT - HDISP);
  localparam logic [VW-1:0] V_AS   = VW'(VTOT - VDISP);

  logic [HW-1:0] h;
  logic [VW-1:0] v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  assign h_sync      = (h >= H_SS) && (h <= H_SE);
  assign v_sync      = (v >= V_SS) && (v <= V_SE);
  assign active      = (h >= H_AS) && (v >= V_AS);
  assign frame_first = (h == '0) && (v == '0);
  assign x           = h - H_AS;
  assign y           = v - V_AS;

endmodule

// File: rtl/vga_pattern_gen.sv
// Mode-selectable VGA source: grid, colour bars, solid colour or external pixel stream.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int   HDISP  = 800,
  parameter int   VDISP  = 480,
  parameter int   HFP    = 40,
  parameter int   HPULSE = 48,
  parameter int   HBP    = 40,
  parameter int   VFP    = 13,
  parameter int   VPULSE = 3,
  parameter int   VBP    = 29,
  parameter logic HS_POL = 1'b0,
  parameter logic VS_POL = 1'b0
) (
  input  logic        pixel_clk,
  input  logic        pixel_rst,
  input  logic [1:0]  mode,
  input  logic [23:0] solid_rgb,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr,
  video_if.master     video_ifm
);

  localparam int HTOT = int'(vga_total(HFP, HPULSE, HBP, HDISP));
  localparam int VTOT = int'(vga_total(VFP, VPULSE, VBP, VDISP));
  localparam int HW   = $clog2(HTOT);
  localparam int VW   = $clog2(VTOT);
  localparam int AW   = $clog2(9 * HDISP + 1);

  logic          h_sync, v_sync, active, frame_first;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic [15:0]   xe, ye;

  vga_timing #(
    .HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
    .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)
  ) u_timing (
    .clk(pixel_clk), .rst(pixel_rst),
    .h_sync(h_sync), .v_sync(v_sync), .active(active),
    .frame_first(frame_first), .x(x), .y(y)
  );

  assign xe = 16'(x);
  assign ye = 16'(y);

  mode_t mode_q;
  logic  hs_q, vs_q, blank_q, fs_q, uf_q;
  rgb_t  rgb_q, pat;

  // Bar index tracks x*8/HDISP: acc = x*8, thr = (idx+1)*HDISP, rearmed every blank.
  logic [AW-1:0] acc, thr;
  logic [2:0]    bar_idx;

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      acc     <= '0;
      thr     <= AW'(HDISP);
      bar_idx <= '0;
    end else if (!active) begin
      acc     <= '0;
      thr     <= AW'(HDISP);
      bar_idx <= '0;
    end else begin
      acc <= acc + AW'(8);
      if (acc + AW'(8) >= thr) begin
        bar_idx <= bar_idx + 1'b1;
        thr     <= thr + AW'(HDISP);
      end
    end
  end

  assign pix_ready = active && (mode_q == STREAM);

  logic starve;
  assign starve = pix_ready && !pix_valid;

  always_comb begin
    pat = '0;
    case (mode_q)
      GRID:    pat = ((xe[3:0] == 4'd0) || (ye[3:0] == 4'd0)) ? rgb_t'(24'hFFFFFF) : rgb_t'(24'h0);
      BARS:    pat = rgb_t'(BAR_PAL[bar_idx]);
      SOLID:   pat = rgb_t'(solid_rgb);
      STREAM:  pat = pix_valid ? rgb_t'(pix_data) : rgb_t'(24'h0);
      default: pat = '0;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      mode_q  <= GRID;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      blank_q <= 1'b0;
      rgb_q   <= '0;
      fs_q    <= 1'b0;
      uf_q    <= 1'b0;
    end else begin
      if (frame_first) mode_q <= mode_t'(mode);
      hs_q    <= h_sync ? HS_POL : ~HS_POL;
      vs_q    <= v_sync ? VS_POL : ~VS_POL;
      blank_q <= active;
      rgb_q   <= active ? pat : '0;
      fs_q    <= frame_first;
      if (starve)             uf_q <= 1'b1;
      else if (underflow_clr) uf_q <= 1'b0;
    end
  end

  assign video_ifm.CLK   = pixel_clk;
  assign video_ifm.HS    = hs_q;
  assign video_ifm.VS    = vs_q;
  assign video_ifm.BLANK = blank_q;
  assign video_ifm.RGB   = rgb_q;
  assign frame_start     = fs_q;
  assign underflow       = uf_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Randomized bench for vga_pattern_gen against a frame-position reference model.
module tb_vga_pattern_gen;
  import vga_pkg::*;

  localparam int HT = 24, VT = 12, HB = 8, VB = 4, FR = HT * VT;

  logic        pixel_clk = 1'b0;
  logic        pixel_rst;
  logic [1:0]  mode;
  logic [23:0] solid_rgb, pix_data;
  logic        pix_valid, pix_ready, frame_start, underflow, underflow_clr;

  video_if vif();

  vga_pattern_gen #(
    .HDISP(16), .VDISP(8), .HFP(2), .HPULSE(3), .HBP(3),
    .VFP(1), .VPULSE(2), .VBP(1), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .pixel_clk(pixel_clk), .pixel_rst(pixel_rst), .mode(mode), .solid_rgb(solid_rgb),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_start(frame_start), .underflow(underflow), .underflow_clr(underflow_clr),
    .video_ifm(vif)
  );

  always #5 pixel_clk = ~pixel_clk;

  int          n_chk = 0, n_pass = 0;
  int          n, xfer;
  mode_t       fmode;
  logic        uf_m;
  logic [23:0] pd_ctr;
  logic [23:0] pal [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                           24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  mode_t       sched [9] = '{GRID, BARS, SOLID, STREAM, STREAM, BARS, SOLID, GRID, GRID};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, n);
  endtask

  task automatic rst_chk(input string p);
    chk({p, "hs"}, 32'(vif.HS), 32'd1);
    chk({p, "vs"}, 32'(vif.VS), 32'd1);
    chk({p, "blank"}, 32'(vif.BLANK), 32'd0);
    chk({p, "rgb"}, 32'(vif.RGB), 32'd0);
    chk({p, "fs"}, 32'(frame_start), 32'd0);
    chk({p, "uf"}, 32'(underflow), 32'd0);
    chk({p, "ready"}, 32'(pix_ready), 32'd0);
  endtask

  // Outputs seen now belong to frame position t with the inputs applied during t.
  task automatic check_out(input int t);
    int h, v, x, y, h2, v2;
    logic act, act2;
    logic [23:0] e;
    h = t % HT;  v = (t / HT) % VT;
    if (h == 0 && v == 0) fmode = mode_t'(mode);
    act = (h >= HB) && (v >= VB);
    x = h - HB;  y = v - VB;
    e = 24'h0;
    if (act) begin
      case (fmode)
        GRID:   e = (x % 16 == 0 || y % 16 == 0) ? 24'hFFFFFF : 24'h0;
        BARS:   e = pal[(x * 8) / 16];
        SOLID:  e = solid_rgb;
        STREAM: e = pix_valid ? pix_data : 24'h0;
        default: e = 24'h0;
      endcase
    end
    if (act && fmode == STREAM && !pix_valid) uf_m = 1'b1;
    else if (underflow_clr) uf_m = 1'b0;
    chk("hs", 32'(vif.HS), (h >= 2 && h <= 4) ? 32'd0 : 32'd1);
    chk("vs", 32'(vif.VS), (v >= 1 && v <= 2) ? 32'd0 : 32'd1);
    chk("blank", 32'(vif.BLANK), 32'(act));
    chk("rgb", 32'(vif.RGB), 32'(e));
    chk("frame_start", 32'(frame_start), (h == 0 && v == 0) ? 32'd1 : 32'd0);
    chk("underflow", 32'(underflow), 32'(uf_m));
    h2 = (t + 1) % HT;  v2 = ((t + 1) / HT) % VT;
    act2 = (h2 >= HB) && (v2 >= VB);
    chk("pix_ready", 32'(pix_ready), 32'(act2 && fmode == STREAM));
  endtask

  task automatic drive(input int t);
    int f, p;
    f = t / FR;  p = t % FR;
    mode = (p >= 150) ? sched[f+1] : sched[f];
    solid_rgb = 24'($urandom);
    if (f == 3) begin
      pix_valid = 1'b1;
      pix_data = pd_ctr;
      pd_ctr = pd_ctr + 24'd1;
      underflow_clr = 1'b0;
    end else begin
      pix_valid = ($urandom % 8) != 0;
      pix_data = 24'($urandom);
      underflow_clr = ($urandom % 4) == 0;
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge pixel_clk);
      n++;
      @(negedge pixel_clk);
      check_out(n - 1);
      if (n % FR == 0) begin
        if (n / FR - 1 == 3) chk("xfer_per_frame", 32'(xfer), 32'd128);
        xfer = 0;
      end
      drive(n);
      if (pix_ready && pix_valid) xfer++;
    end
  endtask

  initial begin
    pixel_rst = 1'b1;  mode = 2'd0;  solid_rgb = '0;  pix_data = '0;
    pix_valid = 1'b0;  underflow_clr = 1'b0;  pd_ctr = '0;  xfer = 0;  n = 0;
    fmode = GRID;  uf_m = 1'b0;
    #3;
    rst_chk("rst_");
    repeat (2) @(posedge pixel_clk);
    @(negedge pixel_clk);
    pixel_rst = 1'b0;
    drive(0);
    run(7 * FR + 100);

    // Asynchronous reset mid-line, between clock edges.
    @(posedge pixel_clk);
    #2 pixel_rst = 1'b1;
    #1 rst_chk("arst_");
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    pixel_rst = 1'b0;
    n = 0;  fmode = GRID;  uf_m = 1'b0;  xfer = 0;
    drive(0);
    run(2 * FR);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised successor of the fixed-timing VGA generator. It has fully configurable horizontal and vertical timing, and each sync output has its own polarity. A run-time mode selects one of four sources: grid test pattern, 8-colour bars, solid colour, or an external pixel stream with a valid/ready handshake. The block drives the shared video_if toward the HDMI/LCD output stage.

Parameters:
HDISP, 800, active pixels per line
VDISP, 480, active lines per frame
HFP, 40, horizontal front porch (pixels)
HPULSE, 48, horizontal sync width
HBP, 40, horizontal back porch
VFP, 13, vertical front porch (lines)
VPULSE, 3, vertical sync width
VBP, 29, vertical back porch
HS_POL, 1'b0, active level of HS
VS_POL, 1'b0, active level of VS

Ports:
pixel_clk  in  1  pixel clock; also drives video_ifm.CLK
pixel_rst  in  1  asynchronous, active-high reset
mode  in  2  source select: 0 GRID, 1 BARS, 2 SOLID, 3 STREAM
solid_rgb  in  24  colour used in SOLID mode
pix_data  in  24  external pixel {R,G,B}
pix_valid  in  1  pix_data valid
pix_ready  out  1  pixel consumed this cycle
frame_start  out  1  one-cycle pulse at the first pixel of a frame
underflow  out  1  sticky: stream starved during active video
underflow_clr  in  1  clears underflow
video_ifm  video_if.master  -  CLK, HS, VS, BLANK, RGB[23:0]

Behaviour:
- Timing constants: HTOT = HFP+HPULSE+HBP+HDISP; VTOT = VFP+VPULSE+VBP+VDISP; HBLK = HTOT-HDISP; VBLK = VTOT-VDISP.
- Line order is FP, pulse, BP, active. Active video occupies h in [HBLK, HTOT-1] and v in [VBLK, VTOT-1].
- Horizontal counter h: 0..HTOT-1, wraps to 0.
- Vertical counter v: increments when h==HTOT-1 and wraps after VTOT-1. Both counters use $clog2 widths.
- Active-video coordinates: x = h-HBLK and y = v-VBLK. Both are meaningful only inside the active area.
- HS is at its active level for h in [HFP, HFP+HPULSE-1]. VS is at its active level for v in [VFP, VFP+VPULSE-1].
- BLANK is 1 inside the active area (display enable) and 0 elsewhere.
- Output latency: all video_ifm outputs and frame_start are registered, 1 cycle after the counter state they decode.
- frame_start is high for exactly one cycle, in the cycle whose outputs correspond to h==0, v==0.
- Mode latching: mode is sampled only when h==0 and v==0 (frame boundary). A mid-frame change takes effect at the next frame. solid_rgb is sampled every cycle.
- GRID mode: RGB = FFFFFF when x[3:0]==0 or y[3:0]==0, otherwise 000000.
- BARS mode: bar index = (x*8)/HDISP, computed with a per-line incrementing comparator, not a divider. Bar colours in order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
- SOLID mode: RGB = solid_rgb.
- STREAM mode handshake:
  - pix_ready = 1 for every active pixel; otherwise pix_ready = 0.
  - A transfer occurs when pix_ready and pix_valid are both 1. RGB = pix_data of that cycle (registered).
  - pix_ready is combinational from the counters and does not depend on pix_valid.
  - Starvation: active pixel with pix_valid=0 gives RGB = 000000 and sets underflow. No stalling: timing never waits for the stream.
- RGB = 000000 whenever BLANK=0, in every mode.
- underflow_clr clears underflow. If a set condition and underflow_clr occur in the same cycle, set wins.
- Reset (asynchronous, any time):
  - h=0, v=0, latched mode=GRID.
  - HS=~HS_POL, VS=~VS_POL, BLANK=0, RGB=0, frame_start=0, underflow=0, pix_ready=0.
  - After release, the first frame_start occurs on the first clock edge (counters start at 0,0).

Decomposition:
- Package vga_pkg holds:
  - mode_t enum (GRID, BARS, SOLID, STREAM);
  - rgb_t (24-bit packed {r,g,b});
  - the 8-entry bar palette constant;
  - a timing-derivation function for HTOT/VTOT.
- Sub-module vga_timing contains the h/v counters and region decode. It outputs h_sync, v_sync, active, frame_first, x, y.
- The top level contains mode latch, pattern mux, stream handshake, underflow flag, and output registers.

Test Plan:
- Bench parameters: HDISP=16, VDISP=8, HFP=2, HPULSE=3, HBP=3, VFP=1, VPULSE=2, VBP=1, giving HTOT=24 and VTOT=12.
- Reset release, GRID mode:
  - HS low for h=2..4 each line (output 1 cycle later); VS low for v=1..2.
  - BLANK high 16 cycles per line, on lines 4..11.
  - frame_start period is 288 cycles.
  - RGB=FFFFFF at x=0 and on line y=0; otherwise 000000.
- BARS mode with HDISP=16: each colour lasts 2 pixels; x=2 gives FFFF00, x=15 gives 000000.
- Mode change to SOLID (solid_rgb=123456) mid-frame: the current frame stays GRID. RGB=123456 from the first active pixel of the next frame.
- STREAM mode, pix_valid always 1 with an incrementing pix_data:
  - exactly 128 transfers per frame;
  - RGB sequence equals pix_data, 1 cycle later;
  - underflow stays 0.
- STREAM mode, pix_valid dropped on one active pixel: that pixel outputs 000000 and underflow rises. A simultaneous underflow_clr on a new starve keeps underflow at 1; a clr with no starve clears it to 0.
- Assert pixel_rst mid-line, asynchronously between clock edges: outputs take reset values immediately without waiting for a clock edge. After release the counters restart at 0,0 and frame_start pulses once on the first clock edge.
